spram_stream_reader: RTL

SPRAM_STREAM_READER -- requirements
Module: spram_stream_reader

---
 rtl/spram_rd_pkg.sv | 13 +
 rtl/spram_stream_reader_fifo2.sv | 61 ++++++
 rtl/spram_stream_reader.sv | 114 +++++++++++
 3 files changed

// File: rtl/spram_rd_pkg.sv
// Shared definitions for the SPRAM stream reader: controller states and
// output FIFO depth.
package spram_rd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_e;

    localparam int unsigned FIFO_DEPTH = 2;

endpackage

// File: rtl/spram_stream_reader_fifo2.sv
// Two-entry FIFO with occupancy count; entry 0 is always the head so the
// head word stays put until it is popped.
module fifo2 #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] head,
    output logic [1:0]   count
);

    logic [W-1:0] ent0_q, ent0_d;
    logic [W-1:0] ent1_q, ent1_d;
    logic [1:0]   count_q, count_d;

    always_comb begin
        ent0_d  = ent0_q;
        ent1_d  = ent1_q;
        count_d = count_q;
        case ({push, pop})
            2'b10: begin
                if (count_q == 2'd0) ent0_d = push_data;
                else                 ent1_d = push_data;
                count_d = count_q + 2'd1;
            end
            2'b01: begin
                ent0_d  = ent1_q;
                count_d = count_q - 2'd1;
            end
            2'b11: begin
                // Same-cycle push and pop: count unchanged, new word goes behind.
                if (count_q == 2'd1) begin
                    ent0_d = push_data;
                end else begin
                    ent0_d = ent1_q;
                    ent1_d = push_data;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ent0_q  <= '0;
            ent1_q  <= '0;
            count_q <= '0;
        end else begin
            ent0_q  <= ent0_d;
            ent1_q  <= ent1_d;
            count_q <= count_d;
        end
    end

    assign head  = ent0_q;
    assign count = count_q;

endmodule

// File: rtl/spram_stream_reader.sv
// Burst reader for a synchronous-read single-port RAM: issues sequential
// reads and streams the returned words out with valid/ready backpressure.
module spram_stream_reader
    import spram_rd_pkg::*;
#(
    parameter int unsigned width   = 8,
    parameter int unsigned widthad = 10
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [widthad-1:0] base_addr,
    input  logic [widthad:0]   length,
    output logic [widthad-1:0] rdaddress,
    input  logic [width-1:0]   q,
    output logic [width-1:0]   out_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               out_last,
    output logic               busy,
    output logic               done
);

    state_e             state_q, state_d;
    logic [widthad-1:0] addr_q, addr_d;
    logic [widthad:0]   rem_q, rem_d;
    logic               inflight_q, inflight_d;
    logic               inflight_last_q, inflight_last_d;
    logic               done_q, done_d;

    logic [width:0]     head;
    logic [1:0]         count;
    logic               pop;
    logic               issue;
    logic [2:0]         occupancy;

    fifo2 #(.W(width + 1)) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (inflight_q),
        .push_data ({inflight_last_q, q}),
        .pop       (pop),
        .head      (head),
        .count     (count)
    );

    assign out_valid = (count != 2'd0);
    assign pop       = out_valid & out_ready;
    assign out_data  = head[width-1:0];
    assign out_last  = out_valid & head[width];

    // Words already held or on their way back, less the one leaving this cycle.
    assign occupancy = {1'b0, count} + {2'b00, inflight_q} - {2'b00, pop};
    assign issue     = (state_q == RUN) && (occupancy < 3'(FIFO_DEPTH));

    always_comb begin
        state_d         = state_q;
        addr_d          = addr_q;
        rem_d           = rem_q;
        done_d          = 1'b0;
        inflight_d      = issue;
        inflight_last_d = issue && (rem_q == (widthad + 1)'(1));
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (length == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = RUN;
                        addr_d  = base_addr;
                        rem_d   = length;
                    end
                end
            end
            RUN: begin
                if (issue) begin
                    addr_d = addr_q + widthad'(1);
                    rem_d  = rem_q - (widthad + 1)'(1);
                    if (rem_q == (widthad + 1)'(1)) state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (pop && head[width]) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= IDLE;
            addr_q          <= '0;
            rem_q           <= '0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
            done_q          <= 1'b0;
        end else begin
            state_q         <= state_d;
            addr_q          <= addr_d;
            rem_q           <= rem_d;
            inflight_q      <= inflight_d;
            inflight_last_q <= inflight_last_d;
            done_q          <= done_d;
        end
    end

    assign rdaddress = addr_q;
    assign busy      = (state_q != IDLE);
    assign done      = done_q;

endmodule
